// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types, defaults and the round-robin pick helper for the cache bus arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (grant hold timeout).
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_C = 2'd1,
      GRANT_M = 2'd2
   } arb_state_e;

   localparam int unsigned NUM_PROC_DEF       = 8;
   localparam int unsigned NUM_SNOOP_DEF      = 8;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

   // Widest requester vector the pick helper supports.
   localparam int unsigned RR_MAX_N = 32;
   localparam int unsigned RR_IDX_W = $clog2(RR_MAX_N);

   // One-hot pick of the first set request at or after (ptr+1) mod n, with wrap.
   function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
      logic [RR_MAX_N-1:0] pick;
      logic                found;
      logic [RR_IDX_W-1:0] idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
         if (i <= n) begin
            idx = RR_IDX_W'((ptr + i) % n);
            if (!found && req[idx]) begin
               pick[idx] = 1'b1;
               found     = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Request/grant bundle between the cache controllers, memory and the bus arbiter.
// Optional feature macro: ARB_TIMEOUT_EN (drives Arb_timeout).
interface cache_bus_arbiter_if
   import cache_arb_pkg::*;
#(
   parameter int unsigned NUM_PROC  = NUM_PROC_DEF,
   parameter int unsigned NUM_SNOOP = NUM_SNOOP_DEF
);

   logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
   logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
   logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
   logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop;
   logic                 Mem_snoop_req;
   logic                 Mem_snoop_gnt;
   logic                 Bus_busy;
   logic                 Arb_timeout;

   // Requesters: caches and lower-level memory.
   modport master (
      output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
      input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_busy, Arb_timeout
   );

   // Arbiter.
   modport slave (
      input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
      output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_busy, Arb_timeout
   );

endinterface

// File: rtl/cache_bus_arbiter_rr_arbiter.sv
// Non-preemptive round-robin arbiter with a lowest-priority fallback requester.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after TIMEOUT grant cycles).
module rr_arbiter
   import cache_arb_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter int unsigned TIMEOUT = TIMEOUT_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         alt_req,
   output logic [N-1:0] gnt,
   output logic         alt_gnt,
   output logic         timeout
);

   arb_state_e          state;
   logic [RR_IDX_W-1:0] ptr;
   logic [RR_MAX_N-1:0] pick_full;
   logic [RR_IDX_W-1:0] pick_idx;

   // Next owner candidate and its index, from the current pointer.
   always_comb begin
      pick_full = rr_pick(RR_MAX_N'(req), 32'(ptr), N);
      pick_idx  = '0;
      for (int unsigned i = 0; i < RR_MAX_N; i++) begin
         if (pick_full[i]) pick_idx = RR_IDX_W'(i);
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;

   // Grant FSM with hold counter; the counter's last value forces release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= RR_IDX_W'(N - 1);
         gnt     <= '0;
         alt_gnt <= 1'b0;
         timeout <= 1'b0;
         cnt     <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt   <= pick_full[N-1:0];
                  ptr   <= pick_idx;
                  cnt   <= '0;
                  state <= GRANT_C;
               end else if (alt_req) begin
                  alt_gnt <= 1'b1;
                  cnt     <= '0;
                  state   <= GRANT_M;
               end
            end
            GRANT_C: begin
               if (!(|(req & gnt))) begin
                  gnt   <= '0;
                  state <= IDLE;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  gnt     <= '0;
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GRANT_M: begin
               if (!alt_req) begin
                  alt_gnt <= 1'b0;
                  state   <= IDLE;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  alt_gnt <= 1'b0;
                  timeout <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               gnt     <= '0;
               alt_gnt <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
`else
   // TIMEOUT only shapes the timeout build; here grants are held indefinitely.
   assign timeout = (TIMEOUT == 0) ? 1'b0 : 1'b0;

   // Grant FSM: hold the owner until it drops its request, then one idle cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= RR_IDX_W'(N - 1);
         gnt     <= '0;
         alt_gnt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt   <= pick_full[N-1:0];
                  ptr   <= pick_idx;
                  state <= GRANT_C;
               end else if (alt_req) begin
                  alt_gnt <= 1'b1;
                  state   <= GRANT_M;
               end
            end
            GRANT_C: begin
               if (!(|(req & gnt))) begin
                  gnt   <= '0;
                  state <= IDLE;
               end
            end
            GRANT_M: begin
               if (!alt_req) begin
                  alt_gnt <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               gnt     <= '0;
               alt_gnt <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
`endif

endmodule

// File: rtl/cache_bus_arbiter.sv
// Common-bus arbiter: independent proc-side and snoop-side round-robin grants,
// memory as lowest-priority snoop requester.
// Optional feature macro: ARB_TIMEOUT_EN (forced release and Arb_timeout pulse).
module cache_bus_arbiter
   import cache_arb_pkg::*;
#(
   parameter int unsigned NUM_PROC       = NUM_PROC_DEF,
   parameter int unsigned NUM_SNOOP      = NUM_SNOOP_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input logic                 clk,
   input logic                 rst,
   cache_bus_arbiter_if.slave  bus
);

   logic [NUM_PROC-1:0]  gnt_proc;
   logic                 proc_alt_gnt;
   logic                 proc_timeout;
   logic [NUM_SNOOP-1:0] gnt_snoop;
   logic                 mem_gnt;
   logic                 snoop_timeout;

   rr_arbiter #(
      .N       (NUM_PROC),
      .TIMEOUT (TIMEOUT_CYCLES)
   ) u_proc (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.Com_Bus_Req_proc),
      .alt_req (1'b0),
      .gnt     (gnt_proc),
      .alt_gnt (proc_alt_gnt),
      .timeout (proc_timeout)
   );

   rr_arbiter #(
      .N       (NUM_SNOOP),
      .TIMEOUT (TIMEOUT_CYCLES)
   ) u_snoop (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.Com_Bus_Req_snoop),
      .alt_req (bus.Mem_snoop_req),
      .gnt     (gnt_snoop),
      .alt_gnt (mem_gnt),
      .timeout (snoop_timeout)
   );

   assign bus.Com_Bus_Gnt_proc  = gnt_proc;
   assign bus.Com_Bus_Gnt_snoop = gnt_snoop;
   assign bus.Mem_snoop_gnt     = mem_gnt;
   // Both are ORs of flop outputs, so they carry no extra latency; simultaneous
   // forced releases on the two sides merge into one pulse.
   assign bus.Bus_busy          = (|gnt_proc) | proc_alt_gnt | (|gnt_snoop) | mem_gnt;
   assign bus.Arb_timeout       = proc_timeout | snoop_timeout;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed, table-driven bench for cache_bus_arbiter.
// Optional feature macro: ARB_TIMEOUT_EN selects the timeout or hold-forever check.
module tb_cache_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_bus_arbiter_if #(.NUM_PROC(8), .NUM_SNOOP(8)) bus ();

   cache_bus_arbiter #(
      .NUM_PROC       (8),
      .NUM_SNOOP      (8),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [7:0] preq;
      logic [7:0] sreq;
      logic       mreq;
      logic [7:0] gp;
      logic [7:0] gs;
      logic       gm;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(input logic [7:0] preq, input logic [7:0] sreq, input logic mreq,
                               input logic [7:0] gp, input logic [7:0] gs, input logic gm);
      vec_t v;
      v.preq = preq; v.sreq = sreq; v.mreq = mreq;
      v.gp = gp; v.gs = gs; v.gm = gm;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic [7:0] gp, input logic [7:0] gs,
                                input logic gm, input logic to);
      check({tag, " gnt_proc"},  32'(bus.Com_Bus_Gnt_proc),  32'(gp));
      check({tag, " gnt_snoop"}, 32'(bus.Com_Bus_Gnt_snoop), 32'(gs));
      check({tag, " mem_gnt"},   32'(bus.Mem_snoop_gnt),     32'(gm));
      check({tag, " busy"},      32'(bus.Bus_busy),          32'((|gp) | (|gs) | gm));
      check({tag, " timeout"},   32'(bus.Arb_timeout),       32'(to));
      check({tag, " onehot_proc"},  32'($onehot0(bus.Com_Bus_Gnt_proc)),  32'd1);
      check({tag, " onehot_snoop"}, 32'($onehot0(bus.Com_Bus_Gnt_snoop)), 32'd1);
      check({tag, " mem_excl"}, 32'(bus.Mem_snoop_gnt & (|bus.Com_Bus_Gnt_snoop)), 32'd0);
   endtask

   task automatic drive(input logic [7:0] preq, input logic [7:0] sreq, input logic mreq);
      bus.Com_Bus_Req_proc  = preq;
      bus.Com_Bus_Req_snoop = sreq;
      bus.Mem_snoop_req     = mreq;
   endtask

   initial begin
      drive(8'h00, 8'h00, 1'b0);

      // Proc round robin through every requester and wrap.
      add(8'hFF, 8'h00, 0, 8'h01, 8'h00, 0);
      add(8'hFE, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'hFE, 8'h00, 0, 8'h02, 8'h00, 0);
      add(8'hFC, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'hFC, 8'h00, 0, 8'h04, 8'h00, 0);
      add(8'hF8, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'hF8, 8'h00, 0, 8'h08, 8'h00, 0);
      add(8'hF0, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'hF0, 8'h00, 0, 8'h10, 8'h00, 0);
      add(8'hE0, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'hE0, 8'h00, 0, 8'h20, 8'h00, 0);
      add(8'hC0, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'hC0, 8'h00, 0, 8'h40, 8'h00, 0);
      add(8'h80, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'h80, 8'h00, 0, 8'h80, 8'h00, 0);
      add(8'h7F, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'h7F, 8'h00, 0, 8'h01, 8'h00, 0);
      add(8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      // No preemption on the proc side.
      add(8'h04, 8'h00, 0, 8'h04, 8'h00, 0);
      add(8'h14, 8'h00, 0, 8'h04, 8'h00, 0);
      add(8'h14, 8'h00, 0, 8'h04, 8'h00, 0);
      add(8'h10, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'h10, 8'h00, 0, 8'h10, 8'h00, 0);
      add(8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      // Memory grant, no preemption by cache 3, gap, then cache 3.
      add(8'h00, 8'h00, 1, 8'h00, 8'h00, 1);
      add(8'h00, 8'h08, 1, 8'h00, 8'h00, 1);
      add(8'h00, 8'h08, 0, 8'h00, 8'h00, 0);
      add(8'h00, 8'h08, 0, 8'h00, 8'h08, 0);
      add(8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      // Cache snoop beats memory from idle; memory gets it afterwards.
      add(8'h00, 8'h01, 1, 8'h00, 8'h01, 0);
      add(8'h00, 8'h00, 1, 8'h00, 8'h00, 0);
      add(8'h00, 8'h00, 1, 8'h00, 8'h00, 1);
      add(8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      // Both sides granted concurrently.
      add(8'h01, 8'h02, 0, 8'h01, 8'h02, 0);
      add(8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
      add(8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

      // Reset state.
      rst = 1'b1;
      repeat (2) tick();
      check_outputs("reset", 8'h00, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].preq, tbl[i].sreq, tbl[i].mreq);
         tick();
         check_outputs($sformatf("vec%0d", i), tbl[i].gp, tbl[i].gs, tbl[i].gm, 1'b0);
      end

      // Request pulse that drops before the edge is never granted.
      drive(8'h01, 8'h00, 1'b0);
      #2;
      drive(8'h00, 8'h00, 1'b0);
      tick();
      check_outputs("pulse", 8'h00, 8'h00, 1'b0, 1'b0);

      // Reset during grant 8'h20 drops it and restores the pointer.
      drive(8'h20, 8'h00, 1'b0);
      tick();
      check_outputs("pre_rst", 8'h20, 8'h00, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      check_outputs("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      drive(8'hFF, 8'h00, 1'b0);
      tick();
      check_outputs("post_rst", 8'h01, 8'h00, 1'b0, 1'b0);
      drive(8'h00, 8'h00, 1'b0);
      tick();

      // Long hold on requester 0 with requester 1 waiting.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(8'h03, 8'h00, 1'b0);
`ifdef ARB_TIMEOUT_EN
      for (int c = 0; c < 4; c++) begin
         tick();
         check_outputs($sformatf("to_hold%0d", c), 8'h01, 8'h00, 1'b0, 1'b0);
      end
      tick();
      check_outputs("to_release", 8'h00, 8'h00, 1'b0, 1'b1);
      tick();
      check_outputs("to_next", 8'h02, 8'h00, 1'b0, 1'b0);
`else
      for (int c = 0; c < 8; c++) begin
         tick();
         check_outputs($sformatf("hold%0d", c), 8'h01, 8'h00, 1'b0, 1'b0);
      end
`endif
      drive(8'h00, 8'h00, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
